// File: rtl/path_trace_sequencer.sv
// Frame sequencer for a path tracer: walks tiles, samples and bounces through the
// ray-gen/trace/shade/accumulate stages. Macro PATH_TRACE_EARLY_TERMINATE_EN enables miss early-out.
module path_trace_sequencer #(
    parameter int unsigned NUM_TILES   = 64,
    parameter int unsigned SPP         = 8,
    parameter int unsigned MAX_BOUNCES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_frame_start,
    output logic                o_frame_busy,
    output logic                o_frame_done,
    output logic                o_gen_start,
    output logic                o_trace_start,
    output logic                o_shade_start,
    output logic                o_accum_start,
    input  logic                i_gen_busy,
    input  logic                i_trace_busy,
    input  logic                i_shade_busy,
    input  logic                i_accum_busy,
    input  logic                i_trace_any_hit,
    output logic [((NUM_TILES > 1) ? $clog2(NUM_TILES) : 1)-1:0]     o_tile_ndx,
    output logic [((SPP > 1) ? $clog2(SPP) : 1)-1:0]                 o_sample_ndx,
    output logic [((MAX_BOUNCES > 1) ? $clog2(MAX_BOUNCES) : 1)-1:0] o_bounce_ndx,
    output logic [31:0]         o_frame_cycles
);

    localparam int unsigned TILE_W   = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int unsigned SAMPLE_W = (SPP > 1) ? $clog2(SPP) : 1;
    localparam int unsigned BOUNCE_W = (MAX_BOUNCES > 1) ? $clog2(MAX_BOUNCES) : 1;

    localparam logic [TILE_W-1:0]   TILE_LAST   = TILE_W'(NUM_TILES - 1);
    localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SPP - 1);
    localparam logic [BOUNCE_W-1:0] BOUNCE_LAST = BOUNCE_W'(MAX_BOUNCES - 1);

    typedef enum logic [3:0] {
        StIdle,
        StGen,
        StGenWait,
        StTrace,
        StTraceWait,
        StShade,
        StShadeWait,
        StAccum,
        StAccumWait,
        StDone
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [TILE_W-1:0]   r_tile_ndx;
    logic [TILE_W-1:0]   w_tile_next;
    logic [SAMPLE_W-1:0] r_sample_ndx;
    logic [SAMPLE_W-1:0] w_sample_next;
    logic [BOUNCE_W-1:0] r_bounce_ndx;
    logic [BOUNCE_W-1:0] w_bounce_next;
    logic                r_hit_latch;
    logic                w_hit_next;
    logic [31:0]         r_frame_cycles;
    logic [31:0]         w_cycles_next;
    logic                w_bounce_end;

`ifdef PATH_TRACE_EARLY_TERMINATE_EN
    // A missed ray is shaded once (sky/environment) and the sample ends there.
    assign w_bounce_end = (r_bounce_ndx == BOUNCE_LAST) || !r_hit_latch;
`else
    logic w_unused_hit_latch;
    assign w_unused_hit_latch = r_hit_latch;
    assign w_bounce_end       = (r_bounce_ndx == BOUNCE_LAST);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= StIdle;
            r_tile_ndx     <= '0;
            r_sample_ndx   <= '0;
            r_bounce_ndx   <= '0;
            r_hit_latch    <= 1'b0;
            r_frame_cycles <= '0;
        end else begin
            r_state        <= w_state_next;
            r_tile_ndx     <= w_tile_next;
            r_sample_ndx   <= w_sample_next;
            r_bounce_ndx   <= w_bounce_next;
            r_hit_latch    <= w_hit_next;
            r_frame_cycles <= w_cycles_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_tile_next   = r_tile_ndx;
        w_sample_next = r_sample_ndx;
        w_bounce_next = r_bounce_ndx;
        w_hit_next    = r_hit_latch;
        w_cycles_next = r_frame_cycles;

        // Counts every busy cycle, DONE included; saturates rather than wraps.
        if (r_state != StIdle && r_frame_cycles != 32'hFFFF_FFFF) begin
            w_cycles_next = r_frame_cycles + 32'd1;
        end

        unique case (r_state)
            StIdle: begin
                if (i_frame_start) begin
                    w_state_next  = StGen;
                    w_tile_next   = '0;
                    w_sample_next = '0;
                    w_bounce_next = '0;
                    w_cycles_next = '0;
                end
            end
            StGen:       w_state_next = StGenWait;
            StGenWait: begin
                if (!i_gen_busy) begin
                    w_state_next  = StTrace;
                    w_bounce_next = '0;
                end
            end
            StTrace:     w_state_next = StTraceWait;
            StTraceWait: begin
                if (!i_trace_busy) begin
                    w_hit_next   = i_trace_any_hit;
                    w_state_next = StShade;
                end
            end
            StShade:     w_state_next = StShadeWait;
            StShadeWait: begin
                if (!i_shade_busy) begin
                    if (w_bounce_end) begin
                        w_state_next = StAccum;
                    end else begin
                        w_bounce_next = r_bounce_ndx + BOUNCE_W'(1);
                        w_state_next  = StTrace;
                    end
                end
            end
            StAccum:     w_state_next = StAccumWait;
            StAccumWait: begin
                if (!i_accum_busy) begin
                    if (r_sample_ndx < SAMPLE_LAST) begin
                        w_sample_next = r_sample_ndx + SAMPLE_W'(1);
                        w_state_next  = StGen;
                    end else begin
                        w_sample_next = '0;
                        if (r_tile_ndx < TILE_LAST) begin
                            w_tile_next  = r_tile_ndx + TILE_W'(1);
                            w_state_next = StGen;
                        end else begin
                            w_state_next = StDone;
                        end
                    end
                end
            end
            StDone:      w_state_next = StIdle;
            default:     w_state_next = StIdle;
        endcase
    end

    // Start pulses come straight from the issue states, so at most one is ever high.
    assign o_gen_start    = (r_state == StGen);
    assign o_trace_start  = (r_state == StTrace);
    assign o_shade_start  = (r_state == StShade);
    assign o_accum_start  = (r_state == StAccum);
    assign o_frame_busy   = (r_state != StIdle);
    assign o_frame_done   = (r_state == StDone);
    assign o_tile_ndx     = r_tile_ndx;
    assign o_sample_ndx   = r_sample_ndx;
    assign o_bounce_ndx   = r_bounce_ndx;
    assign o_frame_cycles = r_frame_cycles;

endmodule

// File: tb/tb_path_trace_sequencer.sv
// Self-checking bench: randomized stage latencies and hit flags against a loop-nest
// reference model of the frame walk, plus a 1x1x1 zero-latency instance.
module tb_path_trace_sequencer;

    localparam int NT = 2;
    localparam int SP = 2;
    localparam int MB = 2;
`ifdef PATH_TRACE_EARLY_TERMINATE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        frame_busy, frame_done;
    logic        gen_start, trace_start, shade_start, accum_start;
    logic        gen_busy, trace_busy, shade_busy, accum_busy;
    logic        r_hit;
    logic [0:0]  tile_ndx, sample_ndx, bounce_ndx;
    logic [31:0] frame_cycles;

    logic        s_frame_start = 1'b0;
    logic        s_busy, s_done, s_gen, s_trace, s_shade, s_accum;
    logic [0:0]  s_tile, s_samp, s_bnc;
    logic [31:0] s_cycles;

    int          lat_tab [256];
    bit          hit_tab [64];
    logic [7:0]  n_start;
    logic [5:0]  n_trace;
    int          gen_cnt, trace_cnt, shade_cnt, accum_cnt;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          s_done_cnt = 0;
    int          s_start_cnt = 0;
    bit          prev_done = 1'b0;
    logic [31:0] act_q [$];
    logic [31:0] exp_q [$];
    logic [31:0] exp_cyc;
    logic [7:0]  cur_k;
    logic [5:0]  cur_h;
    int          cnt_kind [5];

    always #5 clk = ~clk;

    path_trace_sequencer #(.NUM_TILES(NT), .SPP(SP), .MAX_BOUNCES(MB)) u_dut (
        .clk(clk), .rst(rst), .i_frame_start(frame_start),
        .o_frame_busy(frame_busy), .o_frame_done(frame_done),
        .o_gen_start(gen_start), .o_trace_start(trace_start),
        .o_shade_start(shade_start), .o_accum_start(accum_start),
        .i_gen_busy(gen_busy), .i_trace_busy(trace_busy),
        .i_shade_busy(shade_busy), .i_accum_busy(accum_busy),
        .i_trace_any_hit(r_hit), .o_tile_ndx(tile_ndx), .o_sample_ndx(sample_ndx),
        .o_bounce_ndx(bounce_ndx), .o_frame_cycles(frame_cycles)
    );

    path_trace_sequencer #(.NUM_TILES(1), .SPP(1), .MAX_BOUNCES(1)) u_small (
        .clk(clk), .rst(rst), .i_frame_start(s_frame_start),
        .o_frame_busy(s_busy), .o_frame_done(s_done),
        .o_gen_start(s_gen), .o_trace_start(s_trace),
        .o_shade_start(s_shade), .o_accum_start(s_accum),
        .i_gen_busy(1'b0), .i_trace_busy(1'b0), .i_shade_busy(1'b0), .i_accum_busy(1'b0),
        .i_trace_any_hit(1'b1), .o_tile_ndx(s_tile), .o_sample_ndx(s_samp),
        .o_bounce_ndx(s_bnc), .o_frame_cycles(s_cycles)
    );

    // Stage models: each start loads the next latency from the table; busy = counter nonzero.
    always @(posedge clk) begin
        if (rst) begin
            gen_cnt <= 0; trace_cnt <= 0; shade_cnt <= 0; accum_cnt <= 0;
            n_start <= '0; n_trace <= '0; r_hit <= 1'b0;
        end else begin
            if (gen_cnt != 0)   gen_cnt   <= gen_cnt - 1;
            if (trace_cnt != 0) trace_cnt <= trace_cnt - 1;
            if (shade_cnt != 0) shade_cnt <= shade_cnt - 1;
            if (accum_cnt != 0) accum_cnt <= accum_cnt - 1;
            if (gen_start)   gen_cnt   <= lat_tab[n_start];
            if (trace_start) trace_cnt <= lat_tab[n_start];
            if (shade_start) shade_cnt <= lat_tab[n_start];
            if (accum_start) accum_cnt <= lat_tab[n_start];
            if (gen_start | trace_start | shade_start | accum_start) n_start <= n_start + 8'd1;
            if (trace_start) begin
                r_hit   <= hit_tab[n_trace];
                n_trace <= n_trace + 6'd1;
            end
        end
    end

    assign gen_busy   = (gen_cnt != 0);
    assign trace_busy = (trace_cnt != 0);
    assign shade_busy = (shade_cnt != 0);
    assign accum_busy = (accum_cnt != 0);

    function automatic logic [31:0] enc(input int k, input int t, input int s, input int b);
        return 32'(k * 1000 + t * 100 + s * 10 + b);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check("start_onehot",
              32'($countones({gen_start, trace_start, shade_start, accum_start}) <= 1), 32'd1);
        check("gen_while_busy", 32'(gen_start & gen_busy), 32'd0);
        check("trace_while_busy", 32'(trace_start & trace_busy), 32'd0);
        check("shade_while_busy", 32'(shade_start & shade_busy), 32'd0);
        check("accum_while_busy", 32'(accum_start & accum_busy), 32'd0);
        check("done_single_cycle", 32'(frame_done & prev_done), 32'd0);
        prev_done = frame_done;
        if (frame_done) done_cnt++;
        if (!rst) begin
            if (gen_start)   act_q.push_back(enc(1, int'(tile_ndx), int'(sample_ndx), 0));
            if (trace_start) act_q.push_back(enc(2, int'(tile_ndx), int'(sample_ndx), int'(bounce_ndx)));
            if (shade_start) act_q.push_back(enc(3, int'(tile_ndx), int'(sample_ndx), int'(bounce_ndx)));
            if (accum_start) act_q.push_back(enc(4, int'(tile_ndx), int'(sample_ndx), int'(bounce_ndx)));
        end
        s_start_cnt += $countones({s_gen, s_trace, s_shade, s_accum});
        if (s_done) s_done_cnt++;
    endtask

    task automatic fill(input int lo, input int hi, input int hit_mode);
        for (int i = 0; i < 256; i++) lat_tab[i] = int'($urandom_range(hi, lo));
        for (int i = 0; i < 64; i++)
            hit_tab[i] = (hit_mode == 2) ? bit'($urandom_range(1, 0)) : bit'(hit_mode);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        cur_k = '0;
        cur_h = '0;
        act_q.delete();
    endtask

    // Reference: each stage op costs its latency + 2 cycles (issue + final wait), DONE adds 1.
    task automatic model_frame();
        int  b_last;
        bit  hit;
        exp_q.delete();
        exp_cyc = 32'd1;
        for (int t = 0; t < NT; t++) begin
            for (int s = 0; s < SP; s++) begin
                exp_q.push_back(enc(1, t, s, 0));
                exp_cyc += 32'(lat_tab[cur_k]) + 32'd2; cur_k++;
                b_last = 0;
                for (int b = 0; b < MB; b++) begin
                    b_last = b;
                    exp_q.push_back(enc(2, t, s, b));
                    exp_cyc += 32'(lat_tab[cur_k]) + 32'd2; cur_k++;
                    hit = hit_tab[cur_h]; cur_h++;
                    exp_q.push_back(enc(3, t, s, b));
                    exp_cyc += 32'(lat_tab[cur_k]) + 32'd2; cur_k++;
                    if (EARLY && !hit) break;
                end
                exp_q.push_back(enc(4, t, s, b_last));
                exp_cyc += 32'(lat_tab[cur_k]) + 32'd2; cur_k++;
            end
        end
    endtask

    task automatic launch();
        act_q.delete();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("busy_after_start", 32'(frame_busy), 32'd1);
        check("cycles_restart", frame_cycles, 32'd0);
    endtask

    task automatic finish_frame(input bit pulse_mid);
        int d0;
        bit pulsed;
        d0 = done_cnt;
        pulsed = 1'b0;
        for (int n = 0; n < 3000 && done_cnt == d0; n++) begin
            if (pulse_mid && !pulsed && trace_busy) begin
                pulsed = 1'b1;
                frame_start = 1'b1;
                step();
                frame_start = 1'b0;
            end else begin
                step();
            end
        end
        check("frame_done_seen", 32'(done_cnt - d0), 32'd1);
        check("busy_in_done", 32'(frame_busy), 32'd1);
        check("event_count", 32'(act_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            check("event_seq", act_q[i], exp_q[i]);
        for (int k = 0; k < 5; k++) cnt_kind[k] = 0;
        foreach (act_q[i]) if (act_q[i] / 1000 < 5) cnt_kind[act_q[i] / 1000]++;
        act_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(frame_busy), 32'd0);
        check({tag, "_done"}, 32'(frame_done), 32'd0);
        check({tag, "_starts"},
              32'($countones({gen_start, trace_start, shade_start, accum_start})), 32'd0);
        check({tag, "_tile"}, 32'(tile_ndx), 32'd0);
        check({tag, "_sample"}, 32'(sample_ndx), 32'd0);
        check({tag, "_bounce"}, 32'(bounce_ndx), 32'd0);
        check({tag, "_cycles"}, frame_cycles, 32'd0);
    endtask

    initial begin
        logic [31:0] exp_a;
        int          d0;
        bit          found;

        fill(0, 4, 2);
        do_reset();
        check_zero("reset");

        // 1x1x1 with zero-latency stages: nine busy cycles, four starts.
        s_frame_start = 1'b1;
        step();
        s_frame_start = 1'b0;
        for (int n = 0; n < 100 && s_done_cnt == 0; n++) step();
        step();
        check("small_done", 32'(s_done_cnt), 32'd1);
        check("small_cycles", s_cycles, 32'd9);
        check("small_starts", 32'(s_start_cnt), 32'd4);
        check("small_idle", 32'(s_busy), 32'd0);
        check("small_indices", 32'({s_tile, s_samp, s_bnc}), 32'd0);

        // Frame A with a stray frame_start during TRACE_WAIT, then B chained right after DONE.
        model_frame();
        launch();
        finish_frame(1'b1);
        exp_a = exp_cyc;
        model_frame();
        frame_start = 1'b1;
        step();
        check("start_in_done_ignored", 32'(frame_busy), 32'd0);
        check("cycles_hold_idle", frame_cycles, exp_a);
        step();
        frame_start = 1'b0;
        check("chain_busy", 32'(frame_busy), 32'd1);
        check("chain_cycles_restart", frame_cycles, 32'd0);
        finish_frame(1'b0);
        step();
        check("idle_after_b", 32'(frame_busy), 32'd0);
        check("cycles_b", frame_cycles, exp_cyc);

        // Reset while in SHADE_WAIT aborts the frame silently.
        fill(1, 4, 2);
        do_reset();
        launch();
        found = 1'b0;
        for (int n = 0; n < 500 && !found; n++) begin
            step();
            found = shade_busy;
        end
        check("shade_wait_reached", 32'(found), 32'd1);
        rst = 1'b1;
        step();
        check_zero("midreset");
        rst = 1'b0;
        cur_k = '0;
        cur_h = '0;
        d0 = done_cnt;
        repeat (20) step();
        check("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
        check("idle_after_abort", 32'(frame_busy), 32'd0);
        act_q.delete();

        // All rays miss.
        fill(0, 3, 0);
        model_frame();
        launch();
        finish_frame(1'b0);
        check("miss_trace_starts", 32'(cnt_kind[2]), EARLY ? 32'd4 : 32'd8);
        check("miss_accum_starts", 32'(cnt_kind[4]), 32'd4);
        step();
        check("cycles_c", frame_cycles, exp_cyc);

        // All rays hit.
        fill(0, 3, 1);
        model_frame();
        launch();
        finish_frame(1'b0);
        check("hit_gen_starts", 32'(cnt_kind[1]), 32'd4);
        check("hit_trace_starts", 32'(cnt_kind[2]), 32'd8);
        check("hit_shade_starts", 32'(cnt_kind[3]), 32'd8);
        check("hit_accum_starts", 32'(cnt_kind[4]), 32'd4);
        step();
        check("cycles_d", frame_cycles, exp_cyc);
        check("final_tile", 32'(tile_ndx), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/path_trace_sequencer.md
PATH_TRACE_SEQUENCER -- requirements
Module: path_trace_sequencer

Interface
REQ-001 SHALL have parameter NUM_TILES, default 64: pixel tiles per frame (each tile = one RPP ray batch).
REQ-002 SHALL have parameter SPP, default 8: samples per pixel.
REQ-003 SHALL have parameter MAX_BOUNCES, default 4: trace/shade iterations per sample (>=1).
REQ-004 clk  in  1  clock; all logic on posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 frame_start  in  1  one-cycle request to render a frame.
REQ-007 frame_busy  out  1  high from the cycle after accepted frame_start until frame_done.
REQ-008 frame_done  out  1  one-cycle pulse at frame completion.
REQ-009 gen_start / trace_start / shade_start / accum_start  out  1 each  one-cycle start pulses to the ray-gen, trace-rays, shade and accumulate stages.
REQ-010 gen_busy / trace_busy / shade_busy / accum_busy  in  1 each  stage busy; rises the cycle after its start.
REQ-011 trace_any_hit  in  1  trace stage any-hit flag, valid when trace_busy is low.
REQ-012 tile_ndx  out  $clog2(NUM_TILES)  current tile; sample_ndx  out  $clog2(SPP)  current sample; bounce_ndx  out  $clog2(MAX_BOUNCES)  current bounce (min width 1 each).
REQ-013 frame_cycles  out  32  cycle count of the current/last frame.

Function
REQ-014 FSM states SHALL be IDLE, GEN, GEN_WAIT, TRACE, TRACE_WAIT, SHADE, SHADE_WAIT, ACCUM, ACCUM_WAIT, DONE.
REQ-015 IDLE: frame_start -> GEN; tile/sample/bounce indices, frame_cycles cleared to 0.
REQ-016 Each issue state (GEN, TRACE, SHADE, ACCUM) SHALL assert its start output for exactly one cycle and move to its _WAIT state next cycle.
REQ-017 Each _WAIT state SHALL hold until its busy input is sampled low, then advance; busy sampled high on entry is not required (zero-length stage tolerated).
REQ-018 GEN_WAIT -> TRACE with bounce_ndx=0.
REQ-019 TRACE_WAIT SHALL latch trace_any_hit into hit_latch on exit, then -> SHADE.
REQ-020 SHADE_WAIT exit: if bounce_ndx==MAX_BOUNCES-1 (or terminate per REQ-030) -> ACCUM; else bounce_ndx+1 -> TRACE.
REQ-021 ACCUM_WAIT exit: if sample_ndx<SPP-1 -> sample_ndx+1, GEN; else sample_ndx=0 and if tile_ndx<NUM_TILES-1 -> tile_ndx+1, GEN; else -> DONE.
REQ-022 DONE SHALL pulse frame_done one cycle and return to IDLE; indices hold final values until next frame_start.
REQ-023 frame_start while not IDLE SHALL be ignored; frame_start same cycle as DONE ignored.
REQ-024 At most one start output SHALL be high in any cycle; no start issued while the targeted stage busy is high.
REQ-025 frame_busy SHALL be high in all states except IDLE; low in the DONE cycle is not permitted (high through DONE).
REQ-026 frame_cycles SHALL increment every cycle frame_busy is high, saturating at 32'hFFFFFFFF; holds in IDLE.

Reset
REQ-027 rst SHALL force IDLE, all start outputs 0, frame_busy 0, frame_done 0, indices 0, hit_latch 0, frame_cycles 0, taking priority over all inputs.
REQ-028 rst asserted mid-frame SHALL abort the frame with no frame_done pulse; stages are reset externally.

Configuration
REQ-029 Macro PATH_TRACE_EARLY_TERMINATE_EN SHALL control bounce early termination.
REQ-030 Defined: at SHADE_WAIT exit, hit_latch==0 -> ACCUM regardless of bounce_ndx (miss ray shaded once, no further bounces).
REQ-031 Undefined: hit_latch ignored; every sample runs exactly MAX_BOUNCES trace/shade pairs.

Verification
REQ-032 NUM_TILES=2, SPP=2, MAX_BOUNCES=2, stage models busy 3 cycles, any_hit=1: 4 gen, 8 trace, 8 shade, 4 accum starts, then one frame_done; index sequence tile0s0b0,b1,s1... matches.
REQ-033 Same config, any_hit=0, macro defined: 4 trace starts total (bounce_ndx never 1); undefined: 8 trace starts.
REQ-034 frame_start pulsed during TRACE_WAIT -> no effect, single frame_done; frame_start 1 cycle after frame_done -> new frame, frame_cycles restarts at 0.
REQ-035 rst asserted in SHADE_WAIT -> next cycle IDLE, all outputs 0, no frame_done.
REQ-036 Stage model with 0-cycle busy (busy never high) -> each _WAIT lasts 1 cycle; frame_cycles for 1x1x1 config equals 9 (GEN..ACCUM_WAIT plus DONE).
REQ-037 Assertion checks all runs: one-hot-or-zero start outputs, no start while corresponding busy high, frame_done single-cycle.
